// File: rtl/dma_task_arbiter.sv
// Weighted round-robin intake of NUM_CH FWFT task queues into one registered task stream.
// Optional per-channel grant counters are built when DMA_ARB_STATS_EN is defined.
module dma_task_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = $clog2(NUM_CH),
    parameter int unsigned DATA_W = 382,
    parameter int unsigned WGT_W  = 4
) (
    input  logic                       pcie_clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          q_empty,
    input  logic [NUM_CH*DATA_W-1:0]   q_data,
    output logic [NUM_CH-1:0]          q_deq_en,
    input  logic [NUM_CH-1:0]          ch_en,
    input  logic [NUM_CH*WGT_W-1:0]    ch_weight,
    output logic                       task_valid,
    input  logic                       task_ready,
    output logic [DATA_W-1:0]          task_data,
    output logic [CH_W-1:0]            task_ch,
    input  logic [CH_W-1:0]            stat_sel,
    input  logic                       stat_clr,
    output logic [31:0]                stat_cnt
);

    logic [NUM_CH-1:0] req;
    logic              can_load;
    logic              grant;

    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [WGT_W-1:0]  burst_left_q, burst_left_d;

    logic              task_valid_q, task_valid_d;
    logic [DATA_W-1:0] task_data_q, task_data_d;
    logic [CH_W-1:0]   task_ch_q, task_ch_d;

    logic [CH_W-1:0]   cand;
    logic              cand_cont;
    logic              cand_found;
    int                scan_idx;

    logic [DATA_W-1:0] sel_data;
    logic [WGT_W-1:0]  sel_wgt;

    assign req      = ~q_empty & ch_en;
    assign can_load = ~task_valid_q | task_ready;
    // Gated by rst_n so the pop strobe drops asynchronously with the reset.
    assign grant    = rst_n & can_load & (|req);

    // Candidate: stay on cur_ch while its burst lasts, else scan cur_ch+1.. with cur_ch last.
    always_comb begin
        cand       = cur_ch_q;
        cand_cont  = 1'b0;
        cand_found = 1'b0;
        scan_idx   = 0;
        if (req[cur_ch_q] && (burst_left_q != '0)) begin
            cand_cont = 1'b1;
        end else begin
            for (int k = 1; k <= int'(NUM_CH); k++) begin
                scan_idx = int'(cur_ch_q) + k;
                if (scan_idx >= int'(NUM_CH)) begin
                    scan_idx = scan_idx - int'(NUM_CH);
                end
                if (!cand_found && req[scan_idx[CH_W-1:0]]) begin
                    cand_found = 1'b1;
                    cand       = scan_idx[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_wgt  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cand == CH_W'(i)) begin
                sel_data = q_data[i*DATA_W +: DATA_W];
                sel_wgt  = ch_weight[i*WGT_W +: WGT_W];
            end
        end
    end

    assign q_deq_en = grant ? (NUM_CH'(1) << cand) : '0;

    always_comb begin
        cur_ch_d     = cur_ch_q;
        burst_left_d = burst_left_q;
        task_valid_d = task_valid_q;
        task_data_d  = task_data_q;
        task_ch_d    = task_ch_q;
        if (grant) begin
            task_valid_d = 1'b1;
            task_data_d  = sel_data;
            task_ch_d    = cand;
            if (cand_cont) begin
                burst_left_d = burst_left_q - 1'b1;
            end else begin
                cur_ch_d     = cand;
                // A zero weight still earns one grant per turn.
                burst_left_d = (sel_wgt == '0) ? '0 : sel_wgt - 1'b1;
            end
        end else if (task_ready) begin
            task_valid_d = 1'b0;
        end
    end

    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch_q     <= CH_W'(NUM_CH - 1);
            burst_left_q <= '0;
            task_valid_q <= 1'b0;
            task_data_q  <= '0;
            task_ch_q    <= '0;
        end else begin
            cur_ch_q     <= cur_ch_d;
            burst_left_q <= burst_left_d;
            task_valid_q <= task_valid_d;
            task_data_q  <= task_data_d;
            task_ch_q    <= task_ch_d;
        end
    end

    assign task_valid = task_valid_q;
    assign task_data  = task_data_q;
    assign task_ch    = task_ch_q;

`ifdef DMA_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_CH];
    logic [31:0] stat_cnt_q;
    logic [31:0] stat_mux;

    always_comb begin
        stat_mux = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (stat_sel == CH_W'(i)) begin
                stat_mux = grant_cnt_q[i];
            end
        end
    end

    // A clear wins over a grant landing in the same cycle.
    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                grant_cnt_q[i] <= '0;
            end
            stat_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (stat_clr) begin
                    grant_cnt_q[i] <= '0;
                end else if (grant && (cand == CH_W'(i))) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
            end
            stat_cnt_q <= stat_mux;
        end
    end

    assign stat_cnt = stat_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_dma_task_arbiter.sv
// Scoreboard bench for dma_task_arbiter: bench-side FIFO models feed the DUT, expected
// tasks are queued as stimulus is set up and compared on every output handshake.
module tb_dma_task_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 382;
    localparam int WGT_W  = 4;

    typedef struct packed {
        logic [3:0]        ch;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                     pcie_clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        q_empty;
    logic [NUM_CH*DATA_W-1:0] q_data;
    logic [NUM_CH-1:0]        q_deq_en;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*WGT_W-1:0]  ch_weight;
    logic                     task_valid;
    logic                     task_ready;
    logic [DATA_W-1:0]        task_data;
    logic [CH_W-1:0]          task_ch;
    logic [CH_W-1:0]          stat_sel;
    logic                     stat_clr;
    logic [31:0]              stat_cnt;

    // Three-channel instance for the non-power-of-two wrap check.
    logic [2:0]  q3_empty;
    logic [23:0] q3_data;
    logic [2:0]  q3_deq;
    logic [11:0] w3;
    logic        t3_valid;
    logic [7:0]  t3_data;
    logic [1:0]  t3_ch;
    logic [31:0] t3_stat;

    int   fifo_cnt [NUM_CH];
    int   fifo_idx [NUM_CH];
    int   exp_idx  [NUM_CH];
    exp_t sb[$];
    logic [NUM_CH-1:0] last_deq;

    int n_checks = 0;
    int n_fail   = 0;

    dma_task_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .DATA_W (DATA_W),
        .WGT_W  (WGT_W)
    ) dut (
        .pcie_clk   (pcie_clk),
        .rst_n      (rst_n),
        .q_empty    (q_empty),
        .q_data     (q_data),
        .q_deq_en   (q_deq_en),
        .ch_en      (ch_en),
        .ch_weight  (ch_weight),
        .task_valid (task_valid),
        .task_ready (task_ready),
        .task_data  (task_data),
        .task_ch    (task_ch),
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt)
    );

    dma_task_arbiter #(
        .NUM_CH (3),
        .CH_W   (2),
        .DATA_W (8),
        .WGT_W  (4)
    ) dut3 (
        .pcie_clk   (pcie_clk),
        .rst_n      (rst_n),
        .q_empty    (q3_empty),
        .q_data     (q3_data),
        .q_deq_en   (q3_deq),
        .ch_en      (3'b111),
        .ch_weight  (w3),
        .task_valid (t3_valid),
        .task_ready (1'b1),
        .task_data  (t3_data),
        .task_ch    (t3_ch),
        .stat_sel   (2'd0),
        .stat_clr   (1'b0),
        .stat_cnt   (t3_stat)
    );

    initial begin
        pcie_clk = 1'b0;
        forever #5 pcie_clk = ~pcie_clk;
    end

    function automatic logic [DATA_W-1:0] mk_word(input int ch, input int idx);
        logic [DATA_W-1:0] w;
        w = '0;
        w[15:0]           = idx[15:0];
        w[19:16]          = ch[3:0];
        w[DATA_W-1 -: 4]  = ch[3:0];
        w[DATA_W-5 -: 4]  = 4'hC;
        return w;
    endfunction

    always_comb begin
        q_empty = '0;
        q_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            q_empty[c]                  = (fifo_cnt[c] == 0);
            q_data[c*DATA_W +: DATA_W]  = mk_word(c, fifo_idx[c]);
        end
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic env_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_cnt[c] = 0;
            fifo_idx[c] = 0;
            exp_idx[c]  = 0;
        end
        sb.delete();
    endtask

    task automatic expect_item(input int ch);
        exp_t e;
        e.ch   = 4'(ch);
        e.data = mk_word(ch, exp_idx[ch]);
        sb.push_back(e);
        exp_idx[ch]++;
    endtask

    // One cycle: inputs were set at the preceding negedge; sample, clock, then apply pops.
    task automatic tick();
        exp_t e;
        #1;
        last_deq = q_deq_en;
        check_eq("deq_onehot0", 512'($onehot0(last_deq)), 512'(1));
        if (task_valid && !task_ready) check_eq("deq_blocked", 512'(last_deq), 512'(0));
        if (task_valid && task_ready) begin
            check_eq("sb_avail", 512'(sb.size() > 0), 512'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("task_ch", 512'(task_ch), 512'(e.ch));
                check_eq("task_data", 512'(task_data), 512'(e.data));
            end
        end
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (last_deq[c]) begin
                fifo_idx[c]++;
                fifo_cnt[c]--;
            end
        end
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 512'(sb.size()), 512'(0));
    endtask

    task automatic do_reset();
        @(negedge pcie_clk);
        rst_n = 1'b0;
        env_clear();
        ch_en     = 4'hF;
        ch_weight = 16'h1111;
        stat_clr  = 1'b0;
        repeat (2) @(negedge pcie_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        task_ready = 1'b1;
        ch_en      = 4'hF;
        ch_weight  = 16'h1111;
        stat_sel   = '0;
        stat_clr   = 1'b0;
        q3_empty   = 3'b111;
        q3_data    = {8'hA2, 8'hA1, 8'hA0};
        w3         = {4'd2, 4'd1, 4'd1};
        env_clear();
        fifo_cnt[1] = 1;
        fifo_cnt[3] = 1;

        // Reset state, with requests pending.
        #2;
        check_eq("rst_valid", 512'(task_valid), 512'(0));
        check_eq("rst_data", 512'(task_data), 512'(0));
        check_eq("rst_ch", 512'(task_ch), 512'(0));
        check_eq("rst_deq", 512'(q_deq_en), 512'(0));
        check_eq("rst_stat", 512'(stat_cnt), 512'(0));
        @(negedge pcie_clk);
        @(negedge pcie_clk);
        rst_n = 1'b1;
        expect_item(1);
        expect_item(3);
        tick();
        check_eq("first_grant_low", 512'(last_deq), 512'(4'b0010));
        drain("drain_first", 10);

        // Single channel.
        do_reset();
        fifo_cnt[2] = 3;
        repeat (3) expect_item(2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("single_deq", 512'(last_deq), 512'(4'b0100));
        end
        tick();
        check_eq("single_deq_end", 512'(last_deq), 512'(0));
        check_eq("single_idle", 512'(task_valid), 512'(0));
        check_eq("single_sb", 512'(sb.size()), 512'(0));

        // Weighted round robin, weights ch0..ch3 = 1,2,3,1.
        do_reset();
        ch_weight = {4'd1, 4'd3, 4'd2, 4'd1};
        fifo_cnt[0] = 2;
        fifo_cnt[1] = 4;
        fifo_cnt[2] = 6;
        fifo_cnt[3] = 2;
        repeat (2) begin
            expect_item(0);
            repeat (2) expect_item(1);
            repeat (3) expect_item(2);
            expect_item(3);
        end
        repeat (15) tick();
        check_eq("wrr_no_idle", 512'(sb.size()), 512'(0));
        check_eq("wrr_idle_end", 512'(task_valid), 512'(0));

        // Backpressure.
        do_reset();
        fifo_cnt[1] = 4;
        repeat (4) expect_item(1);
        tick();
        task_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_deq", 512'(last_deq), 512'(0));
            check_eq("bp_valid", 512'(task_valid), 512'(1));
            check_eq("bp_ch", 512'(task_ch), 512'(1));
            check_eq("bp_data", 512'(task_data), 512'(mk_word(1, 0)));
        end
        task_ready = 1'b1;
        tick();
        check_eq("bp_resume_deq", 512'(last_deq), 512'(4'b0010));
        drain("drain_bp", 10);

        // Mask and zero weight: ch2 disabled, ch1 weight 0.
        do_reset();
        ch_en     = 4'b1011;
        ch_weight = {4'd1, 4'd2, 4'd0, 4'd1};
        for (int c = 0; c < NUM_CH; c++) fifo_cnt[c] = 10;
        repeat (3) begin
            expect_item(0);
            expect_item(1);
            expect_item(3);
        end
        expect_item(0);
        repeat (10) tick();
        ch_en = 4'b0000;
        drain("drain_mask", 5);

        // Wrap at NUM_CH=3.
        do_reset();
        q3_empty = 3'b011;
        #1;
        check_eq("wrap_first", 512'(q3_deq), 512'(3'b100));
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        #1;
        check_eq("wrap_cont", 512'(q3_deq), 512'(3'b100));
        check_eq("wrap_ch2", 512'(t3_ch), 512'(2));
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        q3_empty = 3'b010;
        #1;
        check_eq("wrap_to_ch0", 512'(q3_deq), 512'(3'b001));
        @(posedge pcie_clk);
        @(negedge pcie_clk);
        check_eq("wrap_out_ch", 512'(t3_ch), 512'(0));
        check_eq("wrap_out_data", 512'(t3_data), 512'(8'hA0));
        q3_empty = 3'b111;

        // Grant statistics.
        do_reset();
        fifo_cnt[1] = 10;
        repeat (10) expect_item(1);
        drain("drain_stats", 20);
        stat_sel = 2'd1;
        tick();
        tick();
`ifdef DMA_ARB_STATS_EN
        check_eq("stat_cnt10", 512'(stat_cnt), 512'(10));
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        tick();
        check_eq("stat_clr", 512'(stat_cnt), 512'(0));
`else
        check_eq("stat_tied0", 512'(stat_cnt), 512'(0));
`endif

        // Asynchronous reset mid-stream.
        do_reset();
        fifo_cnt[0] = 5;
        repeat (5) expect_item(0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 512'(task_valid), 512'(0));
        check_eq("arst_deq", 512'(q_deq_en), 512'(0));
        check_eq("arst_data", 512'(task_data), 512'(0));
        env_clear();
        @(negedge pcie_clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
